// File: rtl/bf16_result_packer_if.sv
// Handshake bundle between the MAC drain and the result packer.
// Input stream of FP32 values, output stream of packed BF16 words.
interface bf16_result_packer_if #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_LANES = 2
);
    logic                   in_valid;
    logic                   in_ready;
    logic [IN_WIDTH-1:0]    in_data;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [16*OUT_LANES-1:0] out_data;
    logic [OUT_LANES-1:0]   out_lane_mask;
    logic                   out_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data,
        input  out_lane_mask, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data,
        output out_lane_mask, out_last
    );
endinterface

// File: rtl/bf16_result_packer.sv
// FP32 -> BF16 (RNE) converter that packs OUT_LANES results per word.
// One register stage, then a pack buffer that doubles as the output register.
module bf16_result_packer #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_LANES = 2,
    parameter bit SAT_EN    = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    bf16_result_packer_if.slave bus,
    output logic nan_seen,
    output logic ovf_seen
);
    localparam int CW = $clog2(OUT_LANES + 1);

    if (IN_WIDTH != 32) begin : g_bad_width
        $error("bf16_result_packer supports IN_WIDTH=32 only");
    end

    logic        cv_sign;
    logic [7:0]  cv_exp;
    logic [22:0] cv_frac;
    logic        cv_rnd;
    logic [15:0] cv_sum;
    logic [15:0] cv_bf16;
    logic        cv_nan;
    logic        cv_ovf;

    always_comb begin
        cv_sign = bus.in_data[31];
        cv_exp  = bus.in_data[30:23];
        cv_frac = bus.in_data[22:0];
        cv_rnd  = bus.in_data[15]
                & (bus.in_data[16] | (|bus.in_data[14:0]));
        cv_sum  = bus.in_data[31:16] + {15'd0, cv_rnd};
        cv_bf16 = cv_sum;
        cv_nan  = 1'b0;
        cv_ovf  = 1'b0;
        unique case (1'b1)
            (cv_exp == 8'hFF) && (cv_frac != '0): begin
                cv_bf16 = 16'h7FC0;
                cv_nan  = 1'b1;
            end
            (cv_exp == 8'hFF) && (cv_frac == '0): begin
                cv_bf16 = {cv_sign, 8'hFF, 7'h0};
            end
            (cv_exp == 8'h00): begin
                cv_bf16 = 16'h0000;
            end
            default: begin
                if (cv_sum[14:7] == 8'hFF) begin
                    cv_ovf  = 1'b1;
                    cv_bf16 = SAT_EN ? {cv_sign, 15'h7F7F}
                                     : {cv_sign, 8'hFF, 7'h0};
                end
            end
        endcase
    end

    logic                    s1_valid_q, s1_valid_d;
    logic [15:0]             s1_bf16_q, s1_bf16_d;
    logic                    s1_last_q, s1_last_d;
    logic [16*OUT_LANES-1:0] data_q, data_d;
    logic [OUT_LANES-1:0]    mask_q, mask_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    last_q, last_d;
    logic                    ovalid_q, ovalid_d;
    logic                    nan_q, nan_d;
    logic                    ovf_q, ovf_d;

    logic pack_adv;
    logic in_fire;
    logic move;

    assign pack_adv = !ovalid_q | bus.out_ready;
    assign bus.in_ready = !clear & (!s1_valid_q | pack_adv);
    assign in_fire  = bus.in_valid & bus.in_ready;
    assign move     = s1_valid_q & pack_adv;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_bf16_d  = s1_bf16_q;
        s1_last_d  = s1_last_q;
        data_d     = data_q;
        mask_d     = mask_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        ovalid_d   = ovalid_q;
        nan_d      = nan_q | (in_fire & cv_nan);
        ovf_d      = ovf_q | (in_fire & cv_ovf);

        // A drained word frees the buffer before the new element lands.
        if (ovalid_q & bus.out_ready) begin
            data_d   = '0;
            mask_d   = '0;
            cnt_d    = '0;
            last_d   = 1'b0;
            ovalid_d = 1'b0;
        end

        if (move) begin
            for (int i = 0; i < OUT_LANES; i++) begin
                if (cnt_d == CW'(i)) begin
                    data_d[16*i +: 16] = s1_bf16_q;
                    mask_d[i]          = 1'b1;
                end
            end
            cnt_d    = cnt_d + CW'(1);
            last_d   = s1_last_q;
            ovalid_d = (cnt_d == CW'(OUT_LANES)) | s1_last_q;
        end

        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_bf16_d  = cv_bf16;
            s1_last_d  = bus.in_last;
        end else if (move) begin
            s1_valid_d = 1'b0;
        end

        if (clear) begin
            s1_valid_d = 1'b0;
            s1_bf16_d  = '0;
            s1_last_d  = 1'b0;
            data_d     = '0;
            mask_d     = '0;
            cnt_d      = '0;
            last_d     = 1'b0;
            ovalid_d   = 1'b0;
            nan_d      = 1'b0;
            ovf_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_bf16_q  <= '0;
            s1_last_q  <= 1'b0;
            data_q     <= '0;
            mask_q     <= '0;
            cnt_q      <= '0;
            last_q     <= 1'b0;
            ovalid_q   <= 1'b0;
            nan_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_bf16_q  <= s1_bf16_d;
            s1_last_q  <= s1_last_d;
            data_q     <= data_d;
            mask_q     <= mask_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            ovalid_q   <= ovalid_d;
            nan_q      <= nan_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.out_valid     = ovalid_q;
    assign bus.out_data      = data_q;
    assign bus.out_lane_mask = mask_q;
    assign bus.out_last      = last_q;
    assign nan_seen          = nan_q;
    assign ovf_seen          = ovf_q;
endmodule
